// File: rtl/sample_splitter.sv
// rtl/sample_splitter.sv - serializes one masked parallel sample into an LSB-first byte stream
module sample_splitter #(
  parameter logic [3:0] S_8BIT  = 4'd0,
  parameter logic [3:0] S_12BIT = 4'd1,
  parameter logic [3:0] S_16BIT = 4'd3,
  parameter logic [3:0] S_24BIT = 4'd4,
  parameter logic [3:0] S_32BIT = 4'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sample_in,
  input  logic [3:0]  sample_size,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_last,
  output logic        sample_err,
  output logic        busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_next;
  logic [31:0] sreg, sreg_next;
  logic [1:0]  idx, idx_next;
  logic [1:0]  last_idx, last_idx_next;
  logic        err_next;

  logic        size_ok;
  logic [31:0] mask;
  logic [1:0]  size_last;
  logic        accept;
  logic        xfer;

  always_comb begin
    size_ok   = 1'b1;
    mask      = 32'h0;
    size_last = 2'd0;
    case (sample_size)
      S_8BIT:  begin mask = 32'h0000_00FF; size_last = 2'd0; end
      S_12BIT: begin mask = 32'h0000_0FFF; size_last = 2'd1; end
      S_16BIT: begin mask = 32'h0000_FFFF; size_last = 2'd1; end
      S_24BIT: begin mask = 32'h00FF_FFFF; size_last = 2'd2; end
      S_32BIT: begin mask = 32'hFFFF_FFFF; size_last = 2'd3; end
      default: size_ok = 1'b0;
    endcase
  end

  // The shift register always presents the current byte in its low 8 bits.
  assign byte_valid   = (state == SEND);
  assign busy         = (state == SEND);
  assign byte_last    = (state == SEND) && (idx == last_idx);
  assign byte_out     = (state == SEND) ? sreg[7:0] : 8'h00;
  assign xfer         = byte_valid && byte_ready;
  assign sample_ready = (state == IDLE) || (xfer && byte_last);
  assign accept       = sample_valid && sample_ready;

  always_comb begin
    state_next    = state;
    sreg_next     = sreg;
    idx_next      = idx;
    last_idx_next = last_idx;
    err_next      = 1'b0;
    if (xfer) begin
      if (idx != last_idx) begin
        idx_next  = idx + 2'd1;
        sreg_next = {8'h00, sreg[31:8]};
      end else begin
        state_next = IDLE;
      end
    end
    // An accept only happens from IDLE or on the final byte, so it may override the above.
    if (accept) begin
      if (size_ok) begin
        state_next    = SEND;
        sreg_next     = sample_in & mask;
        idx_next      = 2'd0;
        last_idx_next = size_last;
      end else begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= 32'h0;
      idx        <= 2'd0;
      last_idx   <= 2'd0;
      sample_err <= 1'b0;
    end else begin
      state      <= state_next;
      sreg       <= sreg_next;
      idx        <= idx_next;
      last_idx   <= last_idx_next;
      sample_err <= err_next;
    end
  end

endmodule

// File: tb/tb_sample_splitter.sv
// tb/tb_sample_splitter.sv - table-driven directed checks for sample_splitter
module tb_sample_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sample_in;
  logic [3:0]  sample_size;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_last;
  logic        sample_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  sample_splitter dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_size  (sample_size),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .byte_last    (byte_last),
    .sample_err   (sample_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] sin;
    logic [3:0]  size;
    logic        sv;
    logic        br;
    logic [7:0]  bo;
    logic        bv;
    logic        bl;
    logic        sr;
    logic        se;
    logic        bz;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [31:0] sin, input logic [3:0] size,
                     input logic sv, input logic br, input logic [7:0] bo, input logic bv,
                     input logic bl, input logic sr, input logic se, input logic bz);
    vec_t v;
    v.rst = r; v.sin = sin; v.size = size; v.sv = sv; v.br = br;
    v.bo = bo; v.bv = bv; v.bl = bl; v.sr = sr; v.se = se; v.bz = bz;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {bo,bv,bl,sr,se,bz}=%h required %h", name, got, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {byte_out, byte_valid, byte_last, sample_ready, sample_err, busy};
  endfunction

  task automatic drive(input logic r, input logic [31:0] sin, input logic [3:0] size,
                       input logic sv, input logic br);
    @(negedge clk);
    rst = r; sample_in = sin; sample_size = size; sample_valid = sv; byte_ready = br;
    #1;
  endtask

  initial begin
    rst = 1'b1; sample_in = 32'h0; sample_size = 4'd0; sample_valid = 1'b0; byte_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset state, then 32-bit DEADBEEF
    add(0, 32'h0,        4'd0, 0, 1, 8'h00, 0, 0, 1, 0, 0);
    add(0, 32'hDEADBEEF, 4'd5, 1, 1, 8'h00, 0, 0, 1, 0, 0);
    add(0, 32'h0,        4'd0, 0, 1, 8'hEF, 1, 0, 0, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'hBE, 1, 0, 0, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'hAD, 1, 0, 0, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'hDE, 1, 1, 1, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'h00, 0, 0, 1, 0, 0);
    // 24-bit
    add(0, 32'hAA123456, 4'd4, 1, 1, 8'h00, 0, 0, 1, 0, 0);
    add(0, 32'h0,        4'd2, 0, 1, 8'h56, 1, 0, 0, 0, 1);
    add(0, 32'h0,        4'd2, 0, 1, 8'h34, 1, 0, 0, 0, 1);
    add(0, 32'h0,        4'd2, 0, 1, 8'h12, 1, 1, 1, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'h00, 0, 0, 1, 0, 0);
    // 12-bit, upper nibble of byte1 masked
    add(0, 32'h0000FABC, 4'd1, 1, 1, 8'h00, 0, 0, 1, 0, 0);
    add(0, 32'h0,        4'd5, 0, 1, 8'hBC, 1, 0, 0, 0, 1);
    add(0, 32'h0,        4'd5, 0, 1, 8'h0A, 1, 1, 1, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'h00, 0, 0, 1, 0, 0);
    // back-to-back 16-bit
    add(0, 32'h1122,     4'd3, 1, 1, 8'h00, 0, 0, 1, 0, 0);
    add(0, 32'h3344,     4'd3, 1, 1, 8'h22, 1, 0, 0, 0, 1);
    add(0, 32'h3344,     4'd3, 1, 1, 8'h11, 1, 1, 1, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'h44, 1, 0, 0, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'h33, 1, 1, 1, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'h00, 0, 0, 1, 0, 0);
    // backpressure 1,0,0,1,1,0,1 with a pending sample offered throughout
    add(0, 32'h01020304, 4'd5, 1, 1, 8'h00, 0, 0, 1, 0, 0);
    add(0, 32'h77,       4'd0, 1, 1, 8'h04, 1, 0, 0, 0, 1);
    add(0, 32'h77,       4'd0, 1, 0, 8'h03, 1, 0, 0, 0, 1);
    add(0, 32'h77,       4'd0, 1, 0, 8'h03, 1, 0, 0, 0, 1);
    add(0, 32'h77,       4'd0, 1, 1, 8'h03, 1, 0, 0, 0, 1);
    add(0, 32'h77,       4'd0, 1, 1, 8'h02, 1, 0, 0, 0, 1);
    add(0, 32'h77,       4'd0, 1, 0, 8'h01, 1, 1, 0, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'h01, 1, 1, 1, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'h00, 0, 0, 1, 0, 0);
    // unsupported code 2, then 8-bit 1FF
    add(0, 32'h55,       4'd2, 1, 1, 8'h00, 0, 0, 1, 0, 0);
    add(0, 32'h0,        4'd0, 0, 1, 8'h00, 0, 0, 1, 1, 0);
    add(0, 32'h1FF,      4'd0, 1, 1, 8'h00, 0, 0, 1, 0, 0);
    add(0, 32'h0,        4'd0, 0, 1, 8'hFF, 1, 1, 1, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'h00, 0, 0, 1, 0, 0);
    // reset after the second byte of a 32-bit sample
    add(0, 32'h0A0B0C0D, 4'd5, 1, 1, 8'h00, 0, 0, 1, 0, 0);
    add(0, 32'h0,        4'd0, 0, 1, 8'h0D, 1, 0, 0, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'h0C, 1, 0, 0, 0, 1);
    add(1, 32'h0,        4'd0, 0, 1, 8'h0B, 1, 0, 0, 0, 1);
    add(0, 32'h0,        4'd0, 0, 1, 8'h00, 0, 0, 1, 0, 0);
    add(0, 32'h0,        4'd0, 0, 1, 8'h00, 0, 0, 1, 0, 0);
    // reset overrides a simultaneous accept
    add(1, 32'h12345678, 4'd5, 1, 1, 8'h00, 0, 0, 1, 0, 0);
    add(0, 32'h0,        4'd0, 0, 1, 8'h00, 0, 0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].sin, vecs[i].size, vecs[i].sv, vecs[i].br);
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].bo, vecs[i].bv, vecs[i].bl, vecs[i].sr, vecs[i].se, vecs[i].bz});
    end

    // continuous 8-bit stream: one byte per cycle across sample boundaries
    for (int c = 0; c < 7; c++) begin
      drive(0, 32'h300 + c, 4'd0, 1, 1);
      if (c == 0) check("stream_idle", outs(), {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      else check($sformatf("stream%0d", c), outs(), {8'(c - 1), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    end
    drive(0, 32'h0, 4'd0, 0, 1);
    check("stream_tail", outs(), {8'h06, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    drive(0, 32'h0, 4'd0, 0, 1);
    check("stream_end", outs(), {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    // unsupported code accepted on the final byte of a send
    drive(0, 32'hBEEF, 4'd3, 1, 1);
    drive(0, 32'h1234, 4'd7, 1, 1);
    check("err_b0", outs(), {8'hEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    drive(0, 32'h1234, 4'd7, 1, 1);
    check("err_b1", outs(), {8'hBE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    drive(0, 32'h0, 4'd0, 0, 1);
    check("err_pulse", outs(), {8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    drive(0, 32'h0, 4'd0, 0, 1);
    check("err_clear", outs(), {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
